// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16
//   UART receiver that oversamples the line at 16x the baud rate. Each bit is
//   decided by a majority vote over three mid-bit samples, and an optional
//   parity bit can be checked. The baud tick generator is built in. The status
//   and data interface matches the existing receiver, so the two can be swapped.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   PARITY_EN  1 = frame carries a parity bit between D7 and stop
//   PARITY_ODD 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rx_en     receiver enable; low aborts any frame and forces IDLE
//   baud_sel  00=9600 01=19200 10=57600 11=115200, latched at start detect
//   rx_in     serial line, idle high, asynchronous to clk
//   RX_DATA   data byte of the last completed frame (error frames included)
//   rx_valid  one-cycle pulse: error-free frame completed
//   rx_error  one-cycle pulse: frame completed with framing/parity error
//   rx_ferr   sticky stop-bit failure flag, cleared by the next rx_valid
//   rx_perr   sticky parity mismatch flag, cleared by the next rx_valid
//   rx_bussy  high while the receiver is not IDLE
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
  parameter int CLK_FREQ   = 32'd50_000_000,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic [1:0] baud_sel,
  input  logic       rx_in,
  output logic [7:0] RX_DATA,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_ferr,
  output logic       rx_perr,
  output logic       rx_bussy
);

  // Clocks per oversample tick for each baud rate (integer-truncated)
  localparam int DIV_9600   = CLK_FREQ / (32'd9600   * 32'd16);
  localparam int DIV_19200  = CLK_FREQ / (32'd19200  * 32'd16);
  localparam int DIV_57600  = CLK_FREQ / (32'd57600  * 32'd16);
  localparam int DIV_115200 = CLK_FREQ / (32'd115200 * 32'd16);

  // The slowest rate has the largest divisor and sets the counter width
  localparam int CNT_W = $clog2(DIV_9600 + 32'd1);

  localparam logic [CNT_W-1:0] DM1_9600   = CNT_W'(DIV_9600   - 32'd1);
  localparam logic [CNT_W-1:0] DM1_19200  = CNT_W'(DIV_19200  - 32'd1);
  localparam logic [CNT_W-1:0] DM1_57600  = CNT_W'(DIV_57600  - 32'd1);
  localparam logic [CNT_W-1:0] DM1_115200 = CNT_W'(DIV_115200 - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Two-of-three majority
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even-parity bit of a byte (XOR reduction)
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

  logic [1:0]       sync_r;
  logic             rxs_s;
  state_t           state_r;
  logic [1:0]       baud_r;
  logic [CNT_W-1:0] tick_cnt_r;
  logic [3:0]       samp_r;
  logic             s7_r;
  logic             s8_r;
  logic [7:0]       shreg_r;
  logic [2:0]       bit_cnt_r;
  logic             perr_frame_r;
  logic             wait_high_r;
  logic [CNT_W-1:0] div_m1_s;
  logic             tick_s;
  logic             decide_s;
  logic             vote_s;

  // Two-flop synchronizer for the asynchronous line, reset to the idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_in};
    end
  end

  assign rxs_s = sync_r[1];

  // Terminal count for the baud rate latched at start detect
  always_comb begin
    div_m1_s = DM1_9600;
    case (baud_r)
      2'b00:   div_m1_s = DM1_9600;
      2'b01:   div_m1_s = DM1_19200;
      2'b10:   div_m1_s = DM1_57600;
      2'b11:   div_m1_s = DM1_115200;
      default: div_m1_s = DM1_9600;
    endcase
  end

  // Tick strobe, bit decision strobe (10th tick of a bit) and the bit vote
  always_comb begin
    tick_s   = 1'b0;
    decide_s = 1'b0;
    if ((state_r != ST_IDLE) && (tick_cnt_r == div_m1_s)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    // Sample counter holds the pre-increment tick index, so 9 marks the 10th tick
    if (tick_s && (samp_r == 4'd9)) begin
      decide_s = 1'b1;
    end else begin
      decide_s = 1'b0;
    end
    vote_s = maj3(s7_r, s8_r, rxs_s);
  end

  // Tick counter: held at 0 in IDLE, so the first tick lands DIV clocks after T0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= CNT_ZERO;
    end else if (!rx_en || (state_r == ST_IDLE)) begin
      tick_cnt_r <= CNT_ZERO;
    end else if (tick_s) begin
      tick_cnt_r <= CNT_ZERO;
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_ONE;
    end
  end

  // Sample counter: position within the current bit, in ticks, wrapping 15->0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_r <= 4'd0;
    end else if (!rx_en || (state_r == ST_IDLE)) begin
      samp_r <= 4'd0;
    end else if (tick_s) begin
      samp_r <= samp_r + 4'd1;
    end
  end

  // Capture the 8th and 9th tick samples; the 10th is taken live in the vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s7_r <= 1'b1;
      s8_r <= 1'b1;
    end else if (tick_s && (samp_r == 4'd7)) begin
      s7_r <= rxs_s;
    end else if (tick_s && (samp_r == 4'd8)) begin
      s8_r <= rxs_s;
    end
  end

  // Frame state machine with registered data, pulses and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      baud_r       <= 2'b00;
      shreg_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
      perr_frame_r <= 1'b0;
      wait_high_r  <= 1'b0;
      RX_DATA      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_error     <= 1'b0;
      rx_ferr      <= 1'b0;
      rx_perr      <= 1'b0;
      rx_bussy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (!rx_en) begin
        // Abort takes priority over any completion decided this cycle
        state_r  <= ST_IDLE;
        rx_bussy <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (wait_high_r) begin
              // After a break, the line must return high before re-arming
              if (rxs_s) begin
                wait_high_r <= 1'b0;
              end
            end else if (!rxs_s) begin
              state_r      <= ST_START;
              baud_r       <= baud_sel;
              perr_frame_r <= 1'b0;
              rx_bussy     <= 1'b1;
            end
          end
          ST_START: begin
            if (decide_s) begin
              if (vote_s) begin
                // Glitch shorter than half a bit: drop silently
                state_r  <= ST_IDLE;
                rx_bussy <= 1'b0;
              end else begin
                state_r   <= ST_DATA;
                bit_cnt_r <= 3'd0;
              end
            end
          end
          ST_DATA: begin
            if (decide_s) begin
              shreg_r   <= {vote_s, shreg_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                if (PARITY_EN) begin
                  state_r <= ST_PARITY;
                end else begin
                  state_r <= ST_STOP;
                end
              end
            end
          end
          ST_PARITY: begin
            if (decide_s) begin
              perr_frame_r <= (vote_s != (parity8(shreg_r) ^ PARITY_ODD));
              state_r      <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (decide_s) begin
              // Leave at the stop-bit decision so a back-to-back start is caught
              RX_DATA  <= shreg_r;
              state_r  <= ST_IDLE;
              rx_bussy <= 1'b0;
              if (vote_s && !perr_frame_r) begin
                rx_valid <= 1'b1;
                rx_ferr  <= 1'b0;
                rx_perr  <= 1'b0;
              end else begin
                rx_error <= 1'b1;
                if (!vote_s) begin
                  rx_ferr     <= 1'b1;
                  wait_high_r <= 1'b1;
                end
                if (perr_frame_r) begin
                  rx_perr <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            rx_bussy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os16
//   Self-checking bench for uart_rx_os16 at CLK_FREQ = 18.432 MHz. Two
//   receivers are instantiated: dut (no parity) on line rx_in and dut_p (even
//   parity) on line rx_in_p. A monitor logs every rx_valid/rx_error cycle into
//   a per-receiver queue. Expected events come from a frame-level model: the
//   outcome is derived from the transmitted bits. The completion cycle follows
//   from the bit index of the stop bit and the divisor.
// -----------------------------------------------------------------------------
module tb_uart_rx_os16;

  localparam int CLK_FREQ = 18_432_000;
  localparam int DIV_FAST = 10;   // 18.432e6 / (115200*16)
  localparam int DIV_SLOW = 120;  // 18.432e6 / (9600*16)

  typedef struct packed {
    logic [31:0] cyc;
    logic        vld;
    logic        err;
    logic [7:0]  data;
    logic        ferr;
    logic        perr;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rx_en;
  logic [1:0] baud_sel;
  logic       rx_in;
  logic       rx_in_p;
  logic [7:0] rd [2];
  logic       vld [2];
  logic       erx [2];
  logic       fe [2];
  logic       pe [2];
  logic       bsy [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  ev_t         evq [2][$];
  logic [7:0]  m_data [2];
  logic        m_ferr [2];
  logic        m_perr [2];

  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .baud_sel(baud_sel), .rx_in(rx_in),
    .RX_DATA(rd[0]), .rx_valid(vld[0]), .rx_error(erx[0]),
    .rx_ferr(fe[0]), .rx_perr(pe[0]), .rx_bussy(bsy[0]));

  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst(rst), .rx_en(rx_en), .baud_sel(baud_sel), .rx_in(rx_in_p),
    .RX_DATA(rd[1]), .rx_valid(vld[1]), .rx_error(erx[1]),
    .rx_ferr(fe[1]), .rx_perr(pe[1]), .rx_bussy(bsy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter plus event log, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (vld[i] || erx[i]) evq[i].push_back('{cyc, vld[i], erx[i], rd[i], fe[i], pe[i]});
    end
  end

  // Stimulus is applied 2 time units after a rising edge
  task automatic align();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Transmit one frame on line i; s returns the cycle the start bit began
  task automatic send_frame(input int i, input logic [7:0] d, input bit par_en,
                            input logic pb, input logic sb, input int bitlen,
                            output logic [31:0] s);
    logic [10:0] bits;
    int          n;
    s = cyc;
    if (par_en) begin
      bits = {sb, pb, d, 1'b0};
      n = 11;
    end else begin
      bits = {1'b1, sb, d, 1'b0};
      n = 10;
    end
    for (int k = 0; k < n; k++) begin
      if (i == 0) rx_in = bits[k]; else rx_in_p = bits[k];
      repeat (bitlen) @(posedge clk);
      #2;
    end
    if (i == 0) rx_in = 1'b1; else rx_in_p = 1'b1;
  endtask

  // Frame-level model (even parity). The stop bit is frame bit 9, or bit 10
  // when parity is present. It is decided on tick 16*n+10 after start detect.
  // The line is seen at the next edge, then 2 synchronizer stages, and the
  // pulse is registered: 3 cycles in total on top of the tick time.
  task automatic predict(input int i, input logic [31:0] s, input logic [7:0] d,
                         input bit par_en, input logic pb, input logic sb,
                         input int div, output ev_t e);
    logic mism;
    logic bad;
    int   nstop;
    mism  = par_en && (pb != ^d);
    bad   = !sb || mism;
    nstop = par_en ? 10 : 9;
    m_data[i] = d;
    if (bad) begin
      if (!sb) m_ferr[i] = 1'b1;
      if (mism) m_perr[i] = 1'b1;
    end else begin
      m_ferr[i] = 1'b0;
      m_perr[i] = 1'b0;
    end
    e = '{s + 32'd3 + 32'(16 * nstop + 10) * 32'(div), !bad, bad, d, m_ferr[i], m_perr[i]};
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_en = 1'b1; rx_in = 1'b1; rx_in_p = 1'b1; baud_sel = 2'b11;
    #1 rst = 1'b0;
    idle(3);
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 8'h00; m_ferr[i] = 1'b0; m_perr[i] = 1'b0;
      n_tests++;
      if ({rd[i], vld[i], erx[i], fe[i], pe[i], bsy[i]} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d got %h want 0", i, {rd[i], vld[i], erx[i], fe[i], pe[i], bsy[i]});
      end
    end
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_clean();
    logic [31:0] s;
    ev_t exp, got;
    baud_sel = 2'b11;
    evq[0].delete();
    align();
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 160, s);
      begin
        repeat (800) @(posedge clk); #1;
        n_tests++;
        if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL clean_busy got %b want 1", bsy[0]); end
      end
    join
    predict(0, s, 8'hA5, 1'b0, 1'b0, 1'b1, DIV_FAST, exp);
    idle(20);
    n_tests++;
    if (evq[0].size() != 1) begin n_fail++; $display("FAIL clean_pulses got %0d want 1", evq[0].size()); end
    else begin
      got = evq[0].pop_front();
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL clean_event got %h want %h", got, exp); end
    end
    n_tests++;
    if ({rd[0], bsy[0]} !== {8'hA5, 1'b0}) begin n_fail++; $display("FAIL clean_hold got %h/%b want a5/0", rd[0], bsy[0]); end
  endtask

  task automatic test_glitch();
    int busy_cnt;
    busy_cnt = 0;
    evq[0].delete();
    align();
    rx_in = 1'b0;
    fork
      begin idle(40); rx_in = 1'b1; end
      for (int k = 0; k < 150; k++) begin
        @(posedge clk); #1;
        if (bsy[0]) busy_cnt++;
      end
    join
    idle(20);
    n_tests++;
    if (busy_cnt != 10 * DIV_FAST) begin n_fail++; $display("FAIL glitch_busy_cycles got %0d want %0d", busy_cnt, 10 * DIV_FAST); end
    n_tests++;
    if (evq[0].size() != 0 || rd[0] !== m_data[0]) begin
      n_fail++; $display("FAIL glitch_quiet got %0d pulses data %h want 0 pulses data %h", evq[0].size(), rd[0], m_data[0]);
    end
  endtask

  task automatic test_framing();
    logic [31:0] s;
    ev_t exp, got;
    logic [7:0] d [3];
    logic       sb [3];
    d[0] = 8'h3C; sb[0] = 1'b0;
    d[1] = 8'h55; sb[1] = 1'b1;
    d[2] = 8'h0F; sb[2] = 1'b1;
    evq[0].delete();
    for (int f = 0; f < 3; f++) begin
      align();
      send_frame(0, d[f], 1'b0, 1'b0, sb[f], 160, s);
      predict(0, s, d[f], 1'b0, 1'b0, sb[f], DIV_FAST, exp);
      idle(20);
      n_tests++;
      if (evq[0].size() != 1) begin n_fail++; $display("FAIL framing_pulses[%0d] got %0d want 1", f, evq[0].size()); end
      else begin
        got = evq[0].pop_front();
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL framing_event[%0d] got %h want %h", f, got, exp); end
      end
      n_tests++;
      if ({rd[0], fe[0]} !== {m_data[0], m_ferr[0]}) begin
        n_fail++; $display("FAIL framing_flags[%0d] got %h/%b want %h/%b", f, rd[0], fe[0], m_data[0], m_ferr[0]);
      end
      if (f == 1) begin
        // Break: line held low well past one frame; exactly one error expected
        align();
        s = cyc;
        rx_in = 1'b0;
        idle(2500);
        rx_in = 1'b1;
        predict(0, s, 8'h00, 1'b0, 1'b0, 1'b0, DIV_FAST, exp);
        idle(40);
        n_tests++;
        if (evq[0].size() != 1) begin n_fail++; $display("FAIL break_pulses got %0d want 1", evq[0].size()); end
        else begin
          got = evq[0].pop_front();
          n_tests++;
          if (got !== exp) begin n_fail++; $display("FAIL break_event got %h want %h", got, exp); end
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [31:0] s;
    ev_t exp, got;
    logic pb [3];
    pb[0] = 1'b1; pb[1] = 1'b0; pb[2] = 1'b1;
    evq[1].delete();
    for (int f = 0; f < 3; f++) begin
      align();
      send_frame(1, 8'h07, 1'b1, pb[f], 1'b1, 160, s);
      predict(1, s, 8'h07, 1'b1, pb[f], 1'b1, DIV_FAST, exp);
      idle(20);
      n_tests++;
      if (evq[1].size() != 1) begin n_fail++; $display("FAIL parity_pulses[%0d] got %0d want 1", f, evq[1].size()); end
      else begin
        got = evq[1].pop_front();
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL parity_event[%0d] got %h want %h", f, got, exp); end
      end
      n_tests++;
      if (pe[1] !== m_perr[1]) begin n_fail++; $display("FAIL parity_flag[%0d] got %b want %b", f, pe[1], m_perr[1]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    ev_t exp, got;
    logic [7:0] d;
    logic sb, pb;
    int bitlen;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 2; i++) begin
        d      = 8'($urandom);
        sb     = ($urandom_range(0, 3) != 0);
        pb     = 1'($urandom_range(0, 1));
        bitlen = 156 + 4 * $urandom_range(0, 2);  // nominal 160 clk/bit, +-2.5%
        evq[i].delete();
        align();
        send_frame(i, d, (i == 1), pb, sb, bitlen, s);
        predict(i, s, d, (i == 1), pb, sb, DIV_FAST, exp);
        idle(20);
        n_tests++;
        if (evq[i].size() != 1) begin n_fail++; $display("FAIL random_pulses[%0d.%0d] got %0d want 1", r, i, evq[i].size()); end
        else begin
          got = evq[i].pop_front();
          n_tests++;
          if (got !== exp) begin n_fail++; $display("FAIL random_event[%0d.%0d] got %h want %h", r, i, got, exp); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s0, s1;
    ev_t exp0, exp1, got0, got1;
    baud_sel = 2'b00;
    evq[0].delete();
    align();
    fork
      begin
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 16 * DIV_SLOW, s0);
        predict(0, s0, 8'h00, 1'b0, 1'b0, 1'b1, DIV_SLOW, exp0);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 16 * DIV_SLOW, s1);
        predict(0, s1, 8'hFF, 1'b0, 1'b0, 1'b1, DIV_SLOW, exp1);
      end
      begin
        // Mid-way through the second frame, select the fast rate
        repeat (10 * 16 * DIV_SLOW + 500) @(posedge clk);
        #2 baud_sel = 2'b11;
      end
    join
    idle(20);
    n_tests++;
    if (evq[0].size() != 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", evq[0].size()); end
    else begin
      got0 = evq[0].pop_front();
      got1 = evq[0].pop_front();
      n_tests++;
      if (got0 !== exp0) begin n_fail++; $display("FAIL b2b_first got %h want %h", got0, exp0); end
      n_tests++;
      if (got1 !== exp1) begin n_fail++; $display("FAIL b2b_second got %h want %h", got1, exp1); end
      n_tests++;
      if (got1.cyc - got0.cyc != 32'(10 * 16 * DIV_SLOW)) begin
        n_fail++; $display("FAIL b2b_spacing got %0d want %0d", got1.cyc - got0.cyc, 10 * 16 * DIV_SLOW);
      end
    end
    baud_sel = 2'b11;
  endtask

  task automatic test_abort();
    logic [31:0] s;
    evq[0].delete();
    align();
    fork
      send_frame(0, 8'($urandom), 1'b0, 1'b0, 1'b1, 160, s);
      begin
        // Middle of D3, which is frame bit 4
        repeat (4 * 160 + 80) @(posedge clk); #1;
        n_tests++;
        if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b want 1", bsy[0]); end
        #1 rx_en = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_idle_next got %b want 0", bsy[0]); end
      end
    join
    rx_en = 1'b1;
    idle(50);
    n_tests++;
    if (evq[0].size() != 0 || {rd[0], fe[0], pe[0]} !== {m_data[0], m_ferr[0], m_perr[0]}) begin
      n_fail++; $display("FAIL abort_quiet got %0d pulses %h/%b/%b want 0 pulses %h/%b/%b",
                         evq[0].size(), rd[0], fe[0], pe[0], m_data[0], m_ferr[0], m_perr[0]);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] s;
    align();
    fork
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 160, s);
      begin
        repeat (500) @(posedge clk); #1;
        n_tests++;
        if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL areset_busy_before got %b want 1", bsy[0]); end
        #2 rst = 1'b0;  // between clock edges
        #1;
        for (int i = 0; i < 2; i++) begin
          n_tests++;
          if ({rd[i], vld[i], erx[i], fe[i], pe[i], bsy[i]} !== 13'd0) begin
            n_fail++; $display("FAIL areset_values dut%0d got %h want 0", i, {rd[i], vld[i], erx[i], fe[i], pe[i], bsy[i]});
          end
        end
      end
    join
    rst = 1'b1;
    idle(5);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_framing();
    test_parity();
    test_random();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
